// File: rtl/dct2d_ctrl_ts.sv
// dct2d_ctrl_ts: row/column sequencer sharing one 8-point 1-D DCT core for an 8x8 2-D DCT
module dct2d_ctrl_ts #(
  parameter int IN_W      = 32,
  parameter int ROW_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [8*IN_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [8*IN_W-1:0] m_data,
  output logic [2:0]        m_idx,
  output logic              m_last,
  output logic              dct_in_valid,
  input  logic              dct_in_ready,
  output logic [8*IN_W-1:0] dct_in,
  input  logic              dct_out_valid,
  output logic              dct_out_ready,
  input  logic [8*IN_W-1:0] dct_out,
  output logic              busy
);
  typedef enum logic [2:0] {ROW_ISSUE, ROW_WAIT, COL_ISSUE, COL_WAIT, DRAIN} state_t;
  localparam int RS1 = ROW_SHIFT > 0 ? ROW_SHIFT - 1 : 0;
  localparam logic [IN_W:0] RND = ROW_SHIFT > 0 ? (IN_W+1)'(1) << RS1 : '0;
  state_t state, state_nxt;
  logic [2:0] row_cnt, col_cnt, row_nxt, col_nxt;
  logic wr;
  logic [IN_W-1:0] tbuf [8][8];
  logic [8*IN_W-1:0] col_vec, rnd_vec;
  logic signed [IN_W:0] ext;
  assign m_data = dct_out;
  assign dct_in = state == COL_ISSUE ? col_vec : s_data;
  assign m_idx  = state == COL_WAIT ? col_cnt : 3'd0;
  assign m_last = state == COL_WAIT && col_cnt == 3'd7;
  assign busy   = !(state == ROW_ISSUE && row_cnt == 3'd0);
  // Round-to-nearest shift of the row-pass result, sign-extended by one bit so the bias cannot overflow
  always_comb begin
    ext = '0;
    rnd_vec = '0;
    for (int k = 0; k < 8; k++) begin
      ext = $signed({dct_out[k*IN_W+IN_W-1], dct_out[k*IN_W +: IN_W]}) + $signed(RND);
      rnd_vec[k*IN_W +: IN_W] = IN_W'(ext >>> ROW_SHIFT);
    end
  end
  // Column col_cnt of the transpose buffer, sample r taken from row r
  always_comb begin
    col_vec = '0;
    for (int r = 0; r < 8; r++) col_vec[r*IN_W +: IN_W] = tbuf[r][col_cnt];
  end
  // Transpose buffer keeps its contents across reset; every block overwrites it fully before reading
  always_ff @(posedge clk) begin
    if (wr) for (int k = 0; k < 8; k++) tbuf[row_cnt][k] <= rnd_vec[k*IN_W +: IN_W];
  end
  // Handshake routing and next-state; abort overrides every handshake
  always_comb begin
    state_nxt = state;
    row_nxt = row_cnt;
    col_nxt = col_cnt;
    wr = 1'b0;
    s_ready = 1'b0;
    dct_in_valid = 1'b0;
    dct_out_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state)
      ROW_ISSUE: begin
        s_ready = !abort && dct_in_ready;
        dct_in_valid = !abort && s_valid;
        if (abort) begin
          row_nxt = '0;
          col_nxt = '0;
        end else if (s_valid && dct_in_ready) state_nxt = ROW_WAIT;
      end
      ROW_WAIT, COL_WAIT: begin
        dct_out_ready = abort || state == ROW_WAIT || m_ready;
        m_valid = !abort && state == COL_WAIT && dct_out_valid;
        if (abort) begin
          row_nxt = '0;
          col_nxt = '0;
          state_nxt = dct_out_valid ? ROW_ISSUE : DRAIN;
        end else if (dct_out_valid && state == ROW_WAIT) begin
          wr = 1'b1;
          row_nxt = row_cnt + 3'd1;
          state_nxt = row_cnt == 3'd7 ? COL_ISSUE : ROW_ISSUE;
        end else if (dct_out_valid && m_ready) begin
          col_nxt = col_cnt + 3'd1;
          state_nxt = col_cnt == 3'd7 ? ROW_ISSUE : COL_ISSUE;
        end
      end
      COL_ISSUE: begin
        dct_in_valid = !abort;
        if (abort) begin
          row_nxt = '0;
          col_nxt = '0;
          state_nxt = ROW_ISSUE;
        end else if (dct_in_ready) state_nxt = COL_WAIT;
      end
      DRAIN: begin
        dct_out_ready = 1'b1;
        if (dct_out_valid) state_nxt = ROW_ISSUE;
      end
      default: state_nxt = ROW_ISSUE;
    endcase
  end
  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ROW_ISSUE;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state <= state_nxt;
      row_cnt <= row_nxt;
      col_cnt <= col_nxt;
    end
  end
endmodule

// File: tb/tb_dct2d_ctrl_ts.sv
// tb_dct2d_ctrl_ts: scoreboard bench running ROW_SHIFT=0 and ROW_SHIFT=1 instances in lockstep
module tb_dct2d_ctrl_ts;
  typedef struct packed {logic [255:0] d; logic [2:0] i; logic l;} exp_t;
  logic clk = 0, rst_n = 0, abort = 0, s_valid = 0, m_ready = 1;
  logic [255:0] s_data = '0;
  logic rnd_mr = 0, rnd_core = 0, mr_def = 1;
  logic ir_sh = 1;
  int lat_sh = 3;
  int checks = 0, errors = 0;
  exp_t q[2][$];
  always #5 clk = ~clk;
  // Shared core randomness keeps both instances cycle-identical
  always @(posedge clk) begin
    ir_sh <= rnd_core ? ($urandom_range(0, 3) != 0) : 1'b1;
    lat_sh <= rnd_core ? int'($urandom_range(0, 5)) : 3;
  end
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    logic s_ready, m_valid, m_last, dct_in_valid, dct_out_valid, dct_out_ready, busy;
    logic [255:0] m_data, dct_in, sd;
    logic [2:0] m_idx;
    logic full = 0;
    int cnt = 0;
    int jobs = 0;
    logic ovl = 0;
    dct2d_ctrl_ts #(.IN_W(32), .ROW_SHIFT(g)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_idx(m_idx), .m_last(m_last),
      .dct_in_valid(dct_in_valid), .dct_in_ready(ir_sh), .dct_in(dct_in),
      .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready), .dct_out(sd),
      .busy(busy)
    );
    assign dct_out_valid = full && cnt == 0;
    // Identity core stub holding a single job
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        full <= 0;
        cnt <= 0;
      end else if (dct_in_valid && ir_sh) begin
        full <= 1;
        sd <= dct_in;
        cnt <= lat_sh;
      end else begin
        if (full && cnt > 0) cnt <= cnt - 1;
        if (dct_out_valid && dct_out_ready) full <= 0;
      end
    end
    always @(posedge clk) begin
      if (rst_n && dct_in_valid && ir_sh) begin
        jobs <= jobs + 1;
        if (full) ovl <= 1;
      end
    end
    // Monitor: every accepted result beat is popped and compared
    always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
        if (q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u%0d unexpected beat idx=%0d data=%h", g, m_idx, m_data);
        end else begin
          exp_t e;
          e = q[g].pop_front();
          chk($sformatf("u%0d beat%0d data", g, e.i), m_data, e.d);
          chk($sformatf("u%0d beat%0d idx", g, e.i), 256'(m_idx), 256'(e.i));
          chk($sformatf("u%0d beat%0d last", g, e.i), 256'(m_last), 256'(e.l));
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    m_ready = rnd_mr ? 1'($urandom_range(0, 1)) : mr_def;
  endtask
  task automatic send_block(input int off, input int n);
    if (n == 8)
      for (int c = 0; c < 8; c++) begin
        exp_t e0, e1;
        e0 = '0;
        e1 = '0;
        for (int v = 0; v < 8; v++) begin
          int x;
          x = 8 * v + c + off;
          e0.d[v*32 +: 32] = x;
          e1.d[v*32 +: 32] = (x + 1) >>> 1;
        end
        e0.i = 3'(c);
        e0.l = c == 7;
        e1.i = 3'(c);
        e1.l = c == 7;
        q[0].push_back(e0);
        q[1].push_back(e1);
      end
    for (int r = 0; r < n; r++) begin
      int t;
      logic ok;
      s_valid = 1;
      for (int k = 0; k < 8; k++) s_data[k*32 +: 32] = 8 * r + k + off;
      for (t = 0; t < 300; t++) begin
        @(negedge clk);
        ok = u[0].s_ready;
        tick();
        if (ok) break;
      end
      if (t == 300) begin
        checks++;
        errors++;
        $display("FAIL row%0d accept timeout", r);
      end
    end
    s_valid = 0;
  endtask
  task automatic wait_idle(input string name);
    int t;
    for (t = 0; t < 2000; t++) begin
      tick();
      if (q[0].size() == 0 && q[1].size() == 0 && !u[0].busy) break;
    end
    if (t == 2000) begin
      checks++;
      errors++;
      $display("FAIL %s idle timeout: pending %0d busy %0d", name, q[0].size(), u[0].busy);
    end
  endtask
  initial begin
    int t, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst s_ready", 256'(u[0].s_ready), 256'(1));
    chk("rst m_valid", 256'(u[0].m_valid), 256'(0));
    chk("rst dct_in_valid", 256'(u[0].dct_in_valid), 256'(0));
    chk("rst dct_out_ready", 256'(u[0].dct_out_ready), 256'(0));
    chk("rst busy", 256'(u[0].busy), 256'(0));
    chk("rst m_idx", 256'(u[0].m_idx), 256'(0));
    chk("rst m_last", 256'(u[0].m_last), 256'(0));
    rst_n = 1;
    send_block(0, 8);
    wait_idle("block0");
    chk("jobs per block", 256'(u[0].jobs), 256'(16));
    rnd_mr = 1;
    rnd_core = 1;
    send_block(17, 8);
    send_block(-40, 8);
    wait_idle("random");
    rnd_mr = 0;
    rnd_core = 0;
    repeat (2) tick();
    send_block(200, 5);
    abort = 1;
    tick();
    abort = 0;
    #1;
    chk("drain busy", 256'(u[0].busy), 256'(1));
    chk("drain out_ready", 256'(u[0].dct_out_ready), 256'(1));
    chk("drain s_ready", 256'(u[0].s_ready), 256'(0));
    chk("drain in_valid", 256'(u[0].dct_in_valid), 256'(0));
    wait_idle("drain");
    send_block(5, 8);
    wait_idle("after drain");
    mr_def = 0;
    tick();
    send_block(60, 8);
    for (t = 0; t < 500; t++) begin
      tick();
      if (u[0].m_valid && u[0].m_idx == 3'd2) break;
      if (u[0].m_valid) m_ready = 1;
    end
    if (t == 500) begin
      checks++;
      errors++;
      $display("FAIL beat2 wait timeout");
    end
    abort = 1;
    #1;
    chk("abort m_valid", 256'(u[0].m_valid), 256'(0));
    chk("abort out_ready", 256'(u[0].dct_out_ready), 256'(1));
    tick();
    abort = 0;
    #1;
    chk("post abort busy", 256'(u[0].busy), 256'(0));
    chk("post abort core empty", 256'(u[0].full), 256'(0));
    chk("post abort s_ready", 256'(u[0].s_ready), 256'(1));
    q[0].delete();
    q[1].delete();
    mr_def = 1;
    send_block(-7, 8);
    wait_idle("after col abort");
    send_block(90, 8);
    n = 0;
    for (t = 0; t < 500; t++) begin
      tick();
      if (u[0].dct_in_valid) n++;
      if (n == 3) break;
    end
    if (t == 500) begin
      checks++;
      errors++;
      $display("FAIL col issue wait timeout");
    end
    rst_n = 0;
    #1;
    chk("mid rst m_valid", 256'(u[0].m_valid), 256'(0));
    chk("mid rst in_valid", 256'(u[0].dct_in_valid), 256'(0));
    chk("mid rst out_ready", 256'(u[0].dct_out_ready), 256'(0));
    chk("mid rst busy", 256'(u[0].busy), 256'(0));
    chk("mid rst m_idx", 256'(u[0].m_idx), 256'(0));
    q[0].delete();
    q[1].delete();
    #2;
    rst_n = 1;
    send_block(33, 8);
    wait_idle("after reset");
    chk("u0 single job in flight", 256'(u[0].ovl), 256'(0));
    chk("u1 single job in flight", 256'(u[1].ovl), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dct2d_ctrl_ts.md
Name: dct2d_ctrl_ts

Overview:
- Row/column sequencer that shares one time-shared 8-point 1-D DCT core between the row pass and the column pass of an 8x8 2-D DCT.
- Accepts an 8x8 block as 8 row beats and sends each row through the core into an internal transpose buffer.
- Then issues the 8 buffer columns to the same core and streams the column results downstream.
- Sits between the block-formatting front end and quantisation.

Parameters:
- IN_W, 32, sample/coefficient width (signed), equal to the core's IN_W.
- ROW_SHIFT, 0, arithmetic right shift with rounding applied to row-pass results before buffering (0 = none, max IN_W-2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous abort of the current block
- s_valid  in  1  upstream row beat valid
- s_ready  out  1  upstream row beat accepted
- s_data  in  8*IN_W  row samples, sample k at bits [k*IN_W +: IN_W]
- m_valid  out  1  result beat valid
- m_ready  in  1  downstream ready
- m_data  out  8*IN_W  result column c, coefficient v at [v*IN_W +: IN_W]
- m_idx  out  3  column index c of current m_data
- m_last  out  1  high on beat c=7
- dct_in_valid  out  1  core input valid
- dct_in_ready  in  1  core input ready
- dct_in  out  8*IN_W  core input samples
- dct_out_valid  in  1  core result valid
- dct_out_ready  out  1  core result accept
- dct_out  in  8*IN_W  core result
- busy  out  1  high in any state except ROW_ISSUE with row_cnt=0

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous, active-low.
- Reset state: ROW_ISSUE, row_cnt=col_cnt=0, transpose buffer not cleared. All valid/ready outputs are 0 in reset, except s_ready follows the ROW_ISSUE rule below. busy=0, m_idx=0, m_last=0.
- Core handshake:
  - At most one core job is in flight at any time.
  - A transfer occurs when valid&&ready are both high at a clk edge.
  - The core may take any number of cycles, including 0 extra, between input and result.
- ROW_ISSUE:
  - Combinational passthrough: dct_in_valid=s_valid, dct_in=s_data, s_ready=dct_in_ready.
  - On transfer -> ROW_WAIT.
- ROW_WAIT:
  - dct_out_ready=1.
  - On dct_out_valid, write the rounded result into tbuf[row_cnt][k] for k=0..7.
  - Rounding: (x + 2^(ROW_SHIFT-1)) >>> ROW_SHIFT when ROW_SHIFT>0, truncated to IN_W bits.
  - If row_cnt=7: row_cnt<=0 and go to COL_ISSUE. Otherwise row_cnt++ and go to ROW_ISSUE.
- COL_ISSUE:
  - dct_in_valid=1, dct_in sample r = tbuf[r][col_cnt].
  - On dct_in_ready -> COL_WAIT.
- COL_WAIT:
  - m_valid=dct_out_valid, m_data=dct_out, dct_out_ready=m_ready, m_idx=col_cnt, m_last=(col_cnt==7).
  - On transfer: if col_cnt=7, col_cnt<=0 and go to ROW_ISSUE (next block). Otherwise col_cnt++ and go to COL_ISSUE.
  - Backpressure from m_ready stalls the core in its output state. There is no buffering in this block.
- Latency: none added by this block. Every core handshake is combinational pass-through plus one state transition.
- abort (priority over all handshakes in the same cycle):
  - In ROW_ISSUE or COL_ISSUE: s_ready, dct_in_valid and m_valid are forced 0 that cycle, counters clear, next state ROW_ISSUE.
  - In ROW_WAIT or COL_WAIT: m_valid forced 0 and dct_out_ready forced 1. If dct_out_valid is high that cycle, the result is dropped and the next state is ROW_ISSUE. Otherwise go to DRAIN.
  - DRAIN: dct_out_ready=1, all other valids 0. On dct_out_valid the result is dropped and the block goes to ROW_ISSUE. abort during DRAIN is ignored.
- Reset mid-block: returns to the reset state immediately. The core is reset by the same rst_n.
- Block-to-block: a new block's row 0 may be accepted the cycle after the m_last transfer.

Test Plan:
- Identity stub core (result = input, 3-cycle latency, ROW_SHIFT=0), block s_data row r sample k = 8r+k -> 8 beats; beat c sample v = 8v+c, m_idx=c, m_last only at c=7; exactly 16 core jobs.
- ROW_SHIFT=1 with the identity stub, same block -> beat c sample v = (8v+c+1)>>1; e.g. beat 3 sample 0 = 2, beat 7 sample 7 = 32.
- Random m_ready (50%) and random stub latency 0-5, two back-to-back blocks -> outputs identical to the no-stall run; never more than one core job in flight; no beat lost or duplicated.
- abort asserted in ROW_WAIT after row 4 is issued with the result pending 2 cycles -> DRAIN entered, the late result is dropped, no m_valid. A following full block produces the correct transpose.
- abort in the same cycle as the COL_WAIT result beat c=2 -> m_valid=0 that cycle, result consumed, next cycle ROW_ISSUE with busy=0.
- rst_n pulsed low in COL_ISSUE -> outputs drop to reset values asynchronously; the next block is processed correctly.
